// File: rtl/alu_op_sequencer.sv
// Command FIFO + issue FSM driving an 8-bit 2-bit-opcode ALU, with a registered response channel.
// Define ALU_SEQ_CHECK_EN to build the result checker that drives the sticky mismatch flag.
module alu_op_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LAT   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [1:0]  cmd_opcode,
    output logic        op_start,
    output logic [7:0]  A,
    output logic [7:0]  B,
    output logic [1:0]  opcode,
    input  logic [15:0] alu_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [1:0]  rsp_opcode,
    output logic        busy,
    output logic        mismatch
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(LAT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [17:0]   mem_q [DEPTH];
    logic [17:0]   head;
    logic          full, empty, push, pop, capture;
    logic [7:0]    op_a_q, op_a_d, op_b_q, op_b_d;
    logic [1:0]    op_opc_q, op_opc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   rsp_data_q, rsp_data_d;
    logic [1:0]    rsp_opc_q, rsp_opc_d;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    assign push  = cmd_valid && !full;

    assign wr_ptr_d = push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    assign rd_ptr_d = pop  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_opc_d   = op_opc_q;
        rsp_data_d = rsp_data_q;
        rsp_opc_d  = rsp_opc_q;
        pop        = 1'b0;
        capture    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    op_a_d   = head[17:10];
                    op_b_d   = head[9:2];
                    op_opc_d = head[1:0];
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CW'(LAT);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == CW'(1)) begin
                    capture    = 1'b1;
                    rsp_data_d = alu_out;
                    rsp_opc_d  = op_opc_q;
                    state_d    = HOLD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HOLD: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_opc_q   <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_opc_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_opc_q   <= op_opc_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_opc_q  <= rsp_opc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {cmd_a, cmd_b, cmd_opcode};
    end

    assign cmd_ready  = !full;
    assign op_start   = (state_q == ISSUE);
    assign A          = op_a_q;
    assign B          = op_b_q;
    assign opcode     = op_opc_q;
    assign rsp_valid  = (state_q == HOLD);
    assign rsp_data   = rsp_data_q;
    assign rsp_opcode = rsp_opc_q;
    assign busy       = (state_q != IDLE) || !empty;

`ifdef ALU_SEQ_CHECK_EN
    logic [15:0] exp_q, exp_d;
    logic        mismatch_q, mismatch_d;

    always_comb begin
        exp_d = exp_q;
        if (state_q == ISSUE) begin
            case (op_opc_q)
                2'd0:    exp_d = {7'b0, {1'b0, op_a_q} + {1'b0, op_b_q}};
                2'd1:    exp_d = {8'b0, op_a_q} * {8'b0, op_b_q};
                2'd2:    exp_d = {8'b0, op_a_q | op_b_q};
                default: exp_d = {8'b0, op_a_q & op_b_q};
            endcase
        end
        mismatch_d = mismatch_q || (capture && (alu_out != exp_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q      <= '0;
            mismatch_q <= 1'b0;
        end else begin
            exp_q      <= exp_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed latency/ordering/full/reset/checker tests
// plus a randomized scoreboard run; a second instance covers LAT=3.
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cmd_valid, cmd_ready, op_start, rsp_valid, rsp_ready, busy, mismatch;
    logic [7:0]  cmd_a, cmd_b, A, B;
    logic [1:0]  cmd_opcode, opcode, rsp_opcode;
    logic [15:0] alu_out, rsp_data;
    logic        alu_force;

    logic        cmd_valid2, cmd_ready2, op_start2, rsp_valid2, rsp_ready2, busy2, mismatch2;
    logic [7:0]  cmd_a2, cmd_b2, A2, B2;
    logic [1:0]  cmd_opcode2, opcode2, rsp_opcode2;
    logic [15:0] alu_out2, rsp_data2;

    int errors = 0;
    int checks = 0;

`ifdef ALU_SEQ_CHECK_EN
    localparam logic EXP_M = 1'b1;
`else
    localparam logic EXP_M = 1'b0;
`endif

    function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        case (op)
            2'd0:    return 16'(a) + 16'(b);
            2'd1:    return 16'(a) * 16'(b);
            2'd2:    return {8'h00, a | b};
            default: return {8'h00, a & b};
        endcase
    endfunction

    assign alu_out = alu_force ? 16'h0000 : alu_ref(A, B, opcode);

    alu_op_sequencer #(.DEPTH(4), .LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_opcode(cmd_opcode), .op_start(op_start),
        .A(A), .B(B), .opcode(opcode), .alu_out(alu_out), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_opcode(rsp_opcode),
        .busy(busy), .mismatch(mismatch)
    );

    alu_op_sequencer #(.DEPTH(4), .LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
        .cmd_a(cmd_a2), .cmd_b(cmd_b2), .cmd_opcode(cmd_opcode2), .op_start(op_start2),
        .A(A2), .B(B2), .opcode(opcode2), .alu_out(alu_out2), .rsp_valid(rsp_valid2),
        .rsp_ready(rsp_ready2), .rsp_data(rsp_data2), .rsp_opcode(rsp_opcode2),
        .busy(busy2), .mismatch(mismatch2)
    );

    function automatic logic [40:0] outs();
        return {cmd_ready, op_start, A, B, opcode, rsp_valid, rsp_data, rsp_opcode, busy, mismatch};
    endfunction

    localparam logic [40:0] RST_OUTS = {1'b1, 40'h0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        cmd_a = a; cmd_b = b; cmd_opcode = op; cmd_valid = 1'b1;
        checks++;
        if (cmd_ready !== 1'b1) $display("FAIL push_ready: cmd_ready=%b expected 1", cmd_ready);
        if (cmd_ready !== 1'b1) errors++;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (outs() !== RST_OUTS) begin
            errors++;
            $display("FAIL reset_outs: got %h expected %h", outs(), RST_OUTS);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        checks++;
        if (outs() !== RST_OUTS) begin
            errors++;
            $display("FAIL post_reset_idle: got %h expected %h", outs(), RST_OUTS);
        end
    endtask

    task automatic test_latency();
        rsp_ready = 1'b1;
        push_cmd(8'hFF, 8'h01, 2'd0);                 // now in c1
        checks++;
        if ({op_start, rsp_valid} !== 2'b00) begin
            errors++; $display("FAIL lat_c1: op_start,rsp_valid=%b%b expected 00", op_start, rsp_valid);
        end
        step();                                       // c2
        checks++;
        if ({op_start, A, B, opcode} !== {1'b1, 8'hFF, 8'h01, 2'd0}) begin
            errors++; $display("FAIL lat_c2_issue: got %b %h %h %h expected 1 ff 01 0", op_start, A, B, opcode);
        end
        step();                                       // c3
        checks++;
        if ({op_start, rsp_valid} !== 2'b00) begin
            errors++; $display("FAIL lat_c3: op_start,rsp_valid=%b%b expected 00", op_start, rsp_valid);
        end
        step();                                       // c4
        checks++;
        if ({rsp_valid, rsp_data, rsp_opcode} !== {1'b1, 16'h0100, 2'd0}) begin
            errors++; $display("FAIL lat_c4_rsp: got %b %h %h expected 1 0100 0", rsp_valid, rsp_data, rsp_opcode);
        end
        step();                                       // c5
        checks++;
        if ({rsp_valid, op_start, A, B, busy} !== {1'b0, 1'b0, 8'hFF, 8'h01, 1'b0}) begin
            errors++; $display("FAIL lat_c5_hold_operands: got %b %b %h %h %b expected 0 0 ff 01 0",
                               rsp_valid, op_start, A, B, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  a [3];
        logic [7:0]  b [3];
        logic [1:0]  op [3];
        logic [15:0] ex [3];
        int          tq[$];
        logic [15:0] dq[$];
        a  = '{8'hFF, 8'hF0, 8'hF0};
        b  = '{8'hFF, 8'h0F, 8'h3C};
        op = '{2'd1, 2'd2, 2'd3};
        ex = '{16'hFE01, 16'h00FF, 16'h0030};
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) push_cmd(a[i], b[i], op[i]);
        for (int t = 3; t < 24; t++) begin
            if (rsp_valid === 1'b1) begin
                tq.push_back(t);
                dq.push_back(rsp_data);
            end
            step();
        end
        checks++;
        if (tq.size() != 3) begin
            errors++; $display("FAIL b2b_count: got %0d responses expected 3", tq.size());
        end
        for (int i = 0; i < 3 && i < tq.size(); i++) begin
            checks++;
            if (dq[i] !== ex[i] || tq[i] != 4 + 4 * i) begin
                errors++;
                $display("FAIL b2b_rsp%0d: data=%h at cycle %0d expected %h at cycle %0d",
                         i, dq[i], tq[i], ex[i], 4 + 4 * i);
            end
        end
    endtask

    task automatic test_full();
        logic [17:0] expq[$];
        logic [7:0]  a, b;
        logic [1:0]  op;
        int          g;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a = 8'($urandom); b = 8'($urandom); op = 2'($urandom_range(0, 3));
            cmd_a = a; cmd_b = b; cmd_opcode = op; cmd_valid = 1'b1;
            g = 0;
            while (cmd_ready !== 1'b1 && g < 20) begin step(); g++; end
            checks++;
            if (g >= 20) begin
                errors++; $display("FAIL full_push%0d_timeout: cmd_ready=%b expected 1", i, cmd_ready);
            end
            expq.push_back({op, alu_ref(a, b, op)});
            step();
        end
        cmd_valid = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++; $display("FAIL full_ready: cmd_ready=%b expected 0", cmd_ready);
        end
        for (int c = 0; c < 6; c++) begin
            checks++;
            if ({op_start, rsp_valid, rsp_opcode, rsp_data} !== {1'b0, 1'b1, expq[0]}) begin
                errors++;
                $display("FAIL full_hold%0d: op_start=%b rsp_valid=%b rsp=%h expected 0 1 %h",
                         c, op_start, rsp_valid, {rsp_opcode, rsp_data}, expq[0]);
            end
            step();
        end
        rsp_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (rsp_valid === 1'b1) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL full_drain_extra: rsp=%h expected none", {rsp_opcode, rsp_data});
                end else if ({rsp_opcode, rsp_data} !== expq[0]) begin
                    errors++; $display("FAIL full_drain: rsp=%h expected %h", {rsp_opcode, rsp_data}, expq[0]);
                    void'(expq.pop_front());
                end else begin
                    void'(expq.pop_front());
                end
            end
            step();
        end
        checks++;
        if (expq.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL full_drain_done: left=%0d busy=%b expected 0 0", expq.size(), busy);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        rsp_ready = 1'b1;
        push_cmd(8'd5, 8'd6, 2'd0);                   // c1
        step(); step();                               // c3 = WAIT
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs() !== RST_OUTS) begin
            errors++; $display("FAIL midrst_async: got %h expected %h", outs(), RST_OUTS);
        end
        step();
        checks++;
        if (outs() !== RST_OUTS) begin
            errors++; $display("FAIL midrst_held: got %h expected %h", outs(), RST_OUTS);
        end
        rst_n = 1'b1;
        step();
        push_cmd(8'd3, 8'd4, 2'd1);
        n = 0;
        for (int c = 0; c < 15; c++) begin
            if (rsp_valid === 1'b1) begin
                n++;
                checks++;
                if ({rsp_opcode, rsp_data} !== {2'd1, 16'h000C}) begin
                    errors++; $display("FAIL midrst_rsp: rsp=%h expected %h", {rsp_opcode, rsp_data}, {2'd1, 16'h000C});
                end
            end
            step();
        end
        checks++;
        if (n != 1) begin
            errors++; $display("FAIL midrst_count: got %0d responses expected 1", n);
        end
    endtask

    task automatic test_mismatch();
        int  g;
        logic early;
        rsp_ready = 1'b1;
        alu_force = 1'b1;
        push_cmd(8'd1, 8'd1, 2'd0);
        g = 0; early = 1'b0;
        while (rsp_valid !== 1'b1 && g < 20) begin
            if (mismatch !== 1'b0) early = 1'b1;
            step(); g++;
        end
        checks++;
        if (g >= 20 || early) begin
            errors++; $display("FAIL mm_before_capture: timeout=%0d early=%b expected 0 0", g >= 20, early);
        end
        checks++;
        if ({rsp_data, mismatch} !== {16'h0000, EXP_M}) begin
            errors++; $display("FAIL mm_capture: rsp_data=%h mismatch=%b expected 0000 %b", rsp_data, mismatch, EXP_M);
        end
        step();
        alu_force = 1'b0;
        push_cmd(8'd2, 8'd3, 2'd0);
        g = 0;
        while (rsp_valid !== 1'b1 && g < 20) begin step(); g++; end
        checks++;
        if (g >= 20 || {rsp_data, mismatch} !== {16'h0005, EXP_M}) begin
            errors++; $display("FAIL mm_sticky: rsp_data=%h mismatch=%b expected 0005 %b", rsp_data, mismatch, EXP_M);
        end
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (mismatch !== 1'b0) begin
            errors++; $display("FAIL mm_cleared: mismatch=%b expected 0", mismatch);
        end
    endtask

    task automatic test_lat3();
        logic [15:0] vals [16];
        logic        seen;
        rsp_ready2 = 1'b1;
        cmd_a2 = 8'h12; cmd_b2 = 8'h34; cmd_opcode2 = 2'd2; cmd_valid2 = 1'b1;
        alu_out2 = 16'($urandom);
        vals[0] = alu_out2;
        checks++;
        if (cmd_ready2 !== 1'b1) begin
            errors++; $display("FAIL lat3_ready: cmd_ready=%b expected 1", cmd_ready2);
        end
        seen = 1'b0;
        for (int k = 1; k < 14; k++) begin
            step();
            cmd_valid2 = 1'b0;
            alu_out2 = 16'($urandom);
            vals[k] = alu_out2;
            if (k == 2) begin
                checks++;
                if ({op_start2, A2, B2, opcode2} !== {1'b1, 8'h12, 8'h34, 2'd2}) begin
                    errors++; $display("FAIL lat3_issue: got %b %h %h %h expected 1 12 34 2", op_start2, A2, B2, opcode2);
                end
            end
            if (rsp_valid2 === 1'b1 && !seen) begin
                seen = 1'b1;
                checks++;
                if (k != 6 || rsp_data2 !== vals[5] || rsp_opcode2 !== 2'd2) begin
                    errors++;
                    $display("FAIL lat3_rsp: cycle=%0d data=%h op=%0d expected cycle 6 data=%h op=2",
                             k, rsp_data2, rsp_opcode2, vals[5]);
                end
            end
        end
        checks++;
        if (!seen || busy2 !== 1'b0) begin
            errors++; $display("FAIL lat3_done: seen=%b busy=%b expected 1 0", seen, busy2);
        end
    endtask

    task automatic test_random();
        localparam int N = 40;
        logic [17:0] q[$];
        logic [17:0] prev;
        logic        held;
        int          sent, recvd;
        sent = 0; recvd = 0; held = 1'b0; prev = '0;
        for (int c = 0; c < 3000 && recvd < N; c++) begin
            if (sent < N && $urandom_range(0, 2) != 0) begin
                cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_opcode = 2'($urandom_range(0, 3));
                cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (cmd_valid && cmd_ready === 1'b1) begin
                q.push_back({cmd_opcode, alu_ref(cmd_a, cmd_b, cmd_opcode)});
                sent++;
            end
            if (rsp_valid === 1'b1) begin
                if (held) begin
                    checks++;
                    if ({rsp_opcode, rsp_data} !== prev) begin
                        errors++; $display("FAIL rnd_stable: rsp=%h expected %h", {rsp_opcode, rsp_data}, prev);
                    end
                end
                if (rsp_ready) begin
                    checks++;
                    recvd++;
                    if (q.size() == 0) begin
                        errors++; $display("FAIL rnd_extra: rsp=%h expected none", {rsp_opcode, rsp_data});
                    end else begin
                        if ({rsp_opcode, rsp_data} !== q[0]) begin
                            errors++; $display("FAIL rnd_rsp: rsp=%h expected %h", {rsp_opcode, rsp_data}, q[0]);
                        end
                        void'(q.pop_front());
                    end
                end
            end
            held = (rsp_valid === 1'b1) && !rsp_ready;
            prev = {rsp_opcode, rsp_data};
            step();
        end
        cmd_valid = 1'b0;
        checks++;
        if (recvd != N || q.size() != 0) begin
            errors++; $display("FAIL rnd_total: received=%0d pending=%0d expected %0d 0", recvd, q.size(), N);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_opcode = '0; rsp_ready = 1'b0; alu_force = 1'b0;
        cmd_valid2 = 1'b0; cmd_a2 = '0; cmd_b2 = '0; cmd_opcode2 = '0; rsp_ready2 = 1'b1; alu_out2 = '0;
        test_reset();
        test_latency();
        test_back_to_back();
        test_full();
        test_mid_reset();
        test_mismatch();
        test_lat3();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
